// File: rtl/sqrt_batch_engine.sv
// sqrt_batch_engine: batch integer square root over an operand RAM.
// The host loads operands, starts a batch with St/Base/Count, and reads
// {remainder, root} words back from the result RAM.
module sqrt_batch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              St,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W:0]   Count,
  input  logic [ADDR_W-1:0] Res_Addr,
  output logic [DATA_W:0]   Res_Data,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Proc_Count
);
  localparam int HALF  = DATA_W / 2;
  localparam int IT_W  = $clog2(HALF);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] ONE_INIT = DATA_W'(1) << (DATA_W-2);
  localparam logic [IT_W-1:0]   LAST_IT  = IT_W'(HALF-1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CALC, S_STORE, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     left_q, left_d;
  logic [ADDR_W:0]     pcnt_q, pcnt_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   one_q, one_d;
  logic [IT_W-1:0]     iter_q, iter_d;

  logic [DATA_W-1:0]   op_mem  [DEPTH];
  logic [DATA_W:0]     res_mem [DEPTH];
  logic [DATA_W-1:0]   op_rd_q;
  logic [DATA_W:0]     res_rd_q;

  logic [ADDR_W:0]     cnt_clamp;
  logic [DATA_W:0]     trial;
  logic                res_we;
  logic [DATA_W:0]     res_wdata;

  assign cnt_clamp  = (Count > MAX_CNT) ? MAX_CNT : Count;
  assign Busy       = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                      (state_q == S_CALC)  || (state_q == S_STORE);
  assign Done       = (state_q == S_FIN);
  assign Proc_Count = pcnt_q;
  assign Res_Data   = res_rd_q;
  assign res_wdata  = {op_q[HALF:0], res_q[HALF-1:0]};

  // Next-state and datapath: one restoring digit-recurrence step per CALC cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    pcnt_d  = pcnt_q;
    op_d    = op_q;
    res_d   = res_q;
    one_d   = one_q;
    iter_d  = iter_q;
    res_we  = 1'b0;
    trial   = {1'b0, res_q} + {1'b0, one_q};
    case (state_q)
      S_IDLE: if (St) begin
        pcnt_d = '0;
        if (cnt_clamp == '0) state_d = S_FIN;
        else begin
          state_d = S_FETCH;
          ptr_d   = Base;
          left_d  = cnt_clamp;
        end
      end
      // Operand RAM read address is ptr_q; data lands in op_rd_q for WAIT
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        op_d    = op_rd_q;
        res_d   = '0;
        one_d   = ONE_INIT;
        iter_d  = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if ({1'b0, op_q} >= trial) begin
          op_d  = op_q - trial[DATA_W-1:0];
          res_d = (res_q >> 1) + one_q;
        end else begin
          res_d = res_q >> 1;
        end
        one_d  = one_q >> 2;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_IT) state_d = S_STORE;
      end
      S_STORE: begin
        res_we  = 1'b1;
        ptr_d   = ptr_q + 1'b1;  // wraps modulo RAM depth
        pcnt_d  = pcnt_q + 1'b1;
        left_d  = left_q - 1'b1;
        state_d = (left_q == (ADDR_W+1)'(1)) ? S_FIN : S_FETCH;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any batch in flight
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      left_q  <= '0;
      pcnt_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
      one_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      pcnt_q  <= pcnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      one_q   <= one_d;
      iter_q  <= iter_d;
    end
  end

  // Operand RAM: host writes only while not busy; registered read at ptr
  always_ff @(posedge CLK) begin
    if (Load_En && !Busy) op_mem[Load_Addr] <= Load_Data;
    op_rd_q <= op_mem[ptr_q];
  end

  // Result RAM write port, contents survive reset
  always_ff @(posedge CLK) begin
    if (res_we) res_mem[ptr_q] <= res_wdata;
  end

  // Result RAM registered host read (old data on same-address write)
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) res_rd_q <= '0;
    else         res_rd_q <= res_mem[Res_Addr];
  end
endmodule

// File: tb/tb_sqrt_batch_engine.sv
// Scoreboard bench for sqrt_batch_engine: queued Done/readback expectations
// from an arithmetic isqrt model, popped by negedge monitors.
module tb_sqrt_batch_engine;
  localparam int AW = 4, DW = 8, BW = 3, DWB = 16;
  localparam int LAT = 3 + DW/2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          ld_en, st, busy, done;
  logic [AW-1:0] ld_addr, base, raddr;
  logic [DW-1:0] ld_data;
  logic [AW:0]   cnt, pcnt;
  logic [DW:0]   rdata;

  logic           ld_en_b, st_b, busy_b, done_b;
  logic [BW-1:0]  ld_addr_b, base_b, raddr_b;
  logic [DWB-1:0] ld_data_b;
  logic [BW:0]    cnt_b, pcnt_b;
  logic [DWB:0]   rdata_b;

  sqrt_batch_engine #(.DATA_W(DW), .ADDR_W(AW)) dut_a (
    .CLK(clk), .ResetN(rst_n), .Load_En(ld_en), .Load_Addr(ld_addr), .Load_Data(ld_data),
    .St(st), .Base(base), .Count(cnt), .Res_Addr(raddr), .Res_Data(rdata),
    .Busy(busy), .Done(done), .Proc_Count(pcnt));

  sqrt_batch_engine #(.DATA_W(DWB), .ADDR_W(BW)) dut_b (
    .CLK(clk), .ResetN(rst_n), .Load_En(ld_en_b), .Load_Addr(ld_addr_b), .Load_Data(ld_data_b),
    .St(st_b), .Base(base_b), .Count(cnt_b), .Res_Addr(raddr_b), .Res_Data(rdata_b),
    .Busy(busy_b), .Done(done_b), .Proc_Count(pcnt_b));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] op_m  [16];
  logic [DW:0]   res_m [16];
  bit            known [16];
  typedef struct {int dcyc; int dn;} done_t;
  done_t        dq[$];
  done_t        dpop;
  logic [DW:0]  rq[$];
  logic [DWB:0] rqb[$];
  bit rd_req = 0, rd_vld = 0, rdb_req = 0, rdb_vld = 0;
  int b_lo = 0, b_hi = 0;

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r+1)*(r+1) <= n) r++;
    return r;
  endfunction

  function automatic logic [DW:0] expect_a(input int n);
    int r = isqrt(n);
    return {5'(n - r*r), 4'(r)};
  endfunction

  function automatic logic [DWB:0] expect_b(input int n);
    int r = isqrt(n);
    return {9'(n - r*r), 8'(r)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    rd_vld  <= rd_req;
    rdb_vld <= rdb_req;
  end

  // Monitor: Busy window, Done pulses and readback data
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (cyc >= b_lo && cyc < b_hi));
      if (done) begin
        chk("done_expected", dq.size() > 0, 1);
        if (dq.size() > 0) begin
          dpop = dq.pop_front();
          chk("done_cycle", cyc, dpop.dcyc);
          chk("proc_count", pcnt, dpop.dn);
        end
      end
      if (rd_vld) begin
        chk("rd_expected", rq.size() > 0, 1);
        if (rq.size() > 0) chk("res_data_a", rdata, rq.pop_front());
      end
      if (rdb_vld) begin
        chk("rdb_expected", rqb.size() > 0, 1);
        if (rqb.size() > 0) chk("res_data_b", rdata_b, rqb.pop_front());
      end
    end
  end

  task automatic load_a(input int a, input int d);
    @(negedge clk);
    ld_en = 1; ld_addr = AW'(a); ld_data = DW'(d);
    op_m[a] = DW'(d);
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic start_a(input int b, input int c);
    int n = (c > 16) ? 16 : c;
    @(negedge clk);
    st = 1; base = AW'(b); cnt = (AW+1)'(c);
    @(posedge clk); #1;
    st = 0;
    dq.push_back('{dcyc: cyc + n*LAT, dn: n});
    b_lo = cyc; b_hi = cyc + n*LAT;
  endtask

  task automatic apply_model(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      int a = (b + i) % 16;
      res_m[a] = expect_a(op_m[a]);
      known[a] = 1;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (dq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    #1;
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: pending %0d required 0", dq.size());
      dq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic readback_a();
    for (int a = 0; a < 16; a++) if (known[a]) begin
      @(negedge clk);
      raddr = AW'(a); rd_req = 1; rq.push_back(res_m[a]);
    end
    @(negedge clk); rd_req = 0;
    @(negedge clk); #1;
    chk("rd_drain", rq.size(), 0);
  endtask

  task automatic batch_a(input int b, input int c);
    int n = (c > 16) ? 16 : c;
    start_a(b, c);
    wait_done();
    apply_model(b, n);
    readback_a();
  endtask

  task automatic load_b(input int a, input int d);
    @(negedge clk);
    ld_en_b = 1; ld_addr_b = BW'(a); ld_data_b = DWB'(d);
    @(negedge clk);
    ld_en_b = 0;
  endtask

  initial begin
    int s, t;
    int vals[8] = '{0, 1, 2, 3, 4, 15, 16, 255};
    int bvals[3] = '{65535, 40000, 1};
    rst_n = 0; ld_en = 0; st = 0; ld_addr = '0; ld_data = '0; base = '0; cnt = '0; raddr = '0;
    ld_en_b = 0; st_b = 0; ld_addr_b = '0; ld_data_b = '0; base_b = '0; cnt_b = '0; raddr_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pcnt", pcnt, 0);
    chk("rst_res_data", rdata, 0);
    chk("rst_res_data_b", rdata_b, 0);
    rst_n = 1;

    for (int a = 0; a < 16; a++) load_a(a, $urandom_range(0, 255));

    // Directed values, Count=8
    for (int a = 0; a < 8; a++) load_a(a, vals[a]);
    batch_a(0, 8);

    // Wrap across the end of the RAM
    load_a(14, 9); load_a(15, 100); load_a(0, 200); load_a(1, 81);
    batch_a(14, 4);

    // Empty batch and clamped oversize batch
    batch_a(5, 0);
    batch_a($urandom_range(0, 15), 31);

    // Interference: dropped load and ignored St during a batch
    load_a(3, 42);
    start_a(0, 8);
    repeat (10) @(negedge clk);
    ld_en = 1; ld_addr = 4'd3; ld_data = 8'd99; st = 1; base = 4'd9; cnt = 5'd2;
    @(negedge clk);
    ld_en = 0; st = 0;
    wait_done();
    repeat (20) @(negedge clk);
    apply_model(0, 8);
    readback_a();

    // Reset during CALC of word 2
    for (int a = 0; a < 8; a++) load_a(a, $urandom_range(0, 255));
    start_a(0, 8);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 0; b_hi = 0; dq.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pcnt", pcnt, 0);
    apply_model(0, 2);
    @(posedge clk); #2;
    rst_n = 1;
    repeat (2) @(negedge clk);
    readback_a();
    batch_a(0, 8);

    // Randomized batches
    for (int k = 0; k < 8; k++) begin
      repeat (3) load_a($urandom_range(0, 15), $urandom_range(0, 255));
      batch_a($urandom_range(0, 15), $urandom_range(0, 31));
    end

    // Wide instance: DATA_W=16, ADDR_W=3
    for (int a = 0; a < 3; a++) load_b(a, bvals[a]);
    @(negedge clk);
    st_b = 1; base_b = '0; cnt_b = 4'd3;
    @(posedge clk); #1;
    st_b = 0; s = cyc; t = 0;
    @(negedge clk);
    while (!done_b && t < 100) begin @(negedge clk); t++; end
    chk("b_done_cycle", cyc, s + 3*(3 + DWB/2));
    chk("b_proc_count", pcnt_b, 3);
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      raddr_b = BW'(a); rdb_req = 1; rqb.push_back(expect_b(bvals[a]));
    end
    @(negedge clk); rdb_req = 0;
    @(negedge clk); #1;
    chk("rdb_drain", rqb.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqrt_batch_engine.md
Name: sqrt_batch_engine

Overview:
- Parametrised successor to the lab 5 RAM-fed square-root datapath.
- Holds an internal operand RAM loaded by the host, then computes the integer square root and remainder of a contiguous block of words using a fixed-latency digit-recurrence algorithm.
- Writes {remainder, root} to an internal result RAM that the host reads back.
- Sits between the test host/loader and downstream display logic, with a Start/Busy/Done handshake.

Parameters:
- DATA_W, 8, operand width in bits; must be even and ≥4.
- ADDR_W, 4, address width; both RAMs have depth 2^ADDR_W.

Ports:
- CLK  in  1  rising-edge clock.
- ResetN  in  1  asynchronous active-low reset.
- Load_En  in  1  write Load_Data to operand RAM at Load_Addr; ignored while Busy=1.
- Load_Addr  in  ADDR_W  operand RAM write address.
- Load_Data  in  DATA_W  operand value.
- St  in  1  start request; sampled in IDLE only.
- Base  in  ADDR_W  first operand address; sampled with St.
- Count  in  ADDR_W+1  number of words; sampled with St; values >2^ADDR_W clamp to 2^ADDR_W.
- Res_Addr  in  ADDR_W  result RAM read address.
- Res_Data  out  DATA_W+1  registered result read: {rem[DATA_W/2:0], root[DATA_W/2-1:0]}; 1-cycle read latency.
- Busy  out  1  high from FETCH through STORE.
- Done  out  1  one-cycle pulse when the batch completes.
- Proc_Count  out  ADDR_W+1  words completed in the current/last batch.

Behaviour:
- Reset values:
  - State=IDLE; Busy=0, Done=0, Proc_Count=0, Res_Data=0.
  - RAM contents are not cleared.
- Reset mid-batch aborts immediately. Partially written results remain, and no Done is issued.
- Both RAMs: synchronous write, registered read. A same-address read during a write returns the old data.
- States: IDLE, FETCH, WAIT, CALC, STORE, FIN.
- IDLE:
  - St=1 with clamped Count=0 → FIN.
  - St=1 with Count>0 → FETCH; latch Base into ptr and Count into remaining; clear Proc_Count.
- FETCH: drive operand RAM address ptr → WAIT.
- WAIT: RAM output valid; load op=data, res=0, one=1<<(DATA_W-2), iter=0 → CALC.
- CALC, one iteration per cycle, DATA_W/2 cycles:
  - If op ≥ res+one: op ← op-(res+one) and res ← (res>>1)+one.
  - Otherwise: res ← res>>1.
  - Then one ← one>>2.
  - After the last iteration → STORE.
- STORE:
  - Write {op[DATA_W/2:0], res[DATA_W/2-1:0]} to result RAM at ptr.
  - ptr ← ptr+1, modulo 2^ADDR_W; wrap is required.
  - Proc_Count+1; remaining-1.
  - If remaining was 1 → FIN, else → FETCH.
- FIN: Done=1, Busy=0 for exactly one cycle → IDLE.
- Timing:
  - Per-word latency is 3+DATA_W/2 cycles.
  - With St accepted at edge 0, Done is high during cycle Count·(3+DATA_W/2)+1.
  - Count=0 gives Done in cycle 1.
- St is ignored outside IDLE, including during FIN. A St held high after FIN starts a new batch on the next IDLE cycle.
- Load_En with Busy=0 (IDLE or FIN) writes normally. Load_En during Busy is dropped; operand RAM is unchanged.
- Result index equals source operand index (ptr), so Base+Count overlapping the wrap point stores at wrapped addresses.
- Arithmetic: op is DATA_W bits; res and one are DATA_W bits. The result satisfies root² ≤ N < (root+1)², and rem = N-root² ≤ 2·root.

Test Plan:
- DATA_W=8: load addr 0..7 with 0,1,2,3,4,15,16,255; St with Base=0, Count=8.
  - Required roots: 0,1,1,1,2,3,4,15.
  - Required rems: 0,0,1,2,0,6,0,30.
  - Done in cycle 57; Proc_Count=8.
- Wrap: Base=14, Count=4 with operands 9,100,200,81 at addr 14,15,0,1.
  - Result RAM at 14,15,0,1 holds roots 3,10,14,9 and rems 0,0,4,0.
  - Other addresses are unchanged.
- Count=0 → Done pulse in cycle 1; Busy never high; no result RAM writes. Count=31 at ADDR_W=4 clamps → 16 words processed, Done in cycle 113.
- Interference: during a batch, assert Load_En to addr 3 with value 99, and pulse St again.
  - Operand RAM addr 3 is unchanged.
  - The second St has no effect.
  - Exactly one Done pulse occurs.
- Reset mid-CALC of word 2: ResetN low for 1 cycle.
  - Busy, Done and Proc_Count drop to 0 immediately.
  - Words 0–1 results are retained.
  - A subsequent full batch completes correctly.
- DATA_W=16, ADDR_W=3: operands 65535, 40000, 1 give roots 255, 200, 1 and rems 510, 0, 0; per-word latency is 11 cycles.
